// File: rtl/lcd_sched_pkg.sv
// Shared types and constants for the LCD frame scheduler.
package lcd_sched_pkg;

  localparam int unsigned LCD_ADDR_W = 6;
  localparam int unsigned LCD_DATA_W = 8;
  localparam logic [7:0]  BLANK_CHAR = 8'h20;
  localparam int unsigned LINE_CHARS = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_TRIG      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_PRINT     = 2'd3
  } state_t;

  // Round-robin successor of idx in a ring of n requesters.
  function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Round-robin one-hot grant: lowest-index valid requester at or after ptr.
module lcd_rr_arbiter
  import lcd_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic               enable,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   next_ptr
);

  logic [NUM_REQ-1:0] upper;

  always_comb begin
    upper = '0;
    for (int j = 0; j < int'(NUM_REQ); j++) begin
      upper[j] = valid[j] && (PTR_W'(j) >= ptr);
    end
  end

  // Descending scans leave the lowest hit; the at-or-after-ptr scan overrides the wrap scan.
  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    if (enable) begin
      for (int j = int'(NUM_REQ) - 1; j >= 0; j--) begin
        if (valid[j]) begin
          grant    = '0;
          grant[j] = 1'b1;
          next_ptr = PTR_W'(rr_wrap(32'(j), NUM_REQ));
        end
      end
      if (|upper) begin
        for (int j = int'(NUM_REQ) - 1; j >= 0; j--) begin
          if (upper[j]) begin
            grant    = '0;
            grant[j] = 1'b1;
            next_ptr = PTR_W'(rr_wrap(32'(j), NUM_REQ));
          end
        end
      end
    end
  end

endmodule

// File: rtl/lcd_frame_scheduler.sv
// LCD text buffer, write arbitration and frame trigger sequencing for the HD44780 driver.
// Build option LCD_SCHED_PERIODIC_EN: relaunch frames every period even when not dirty.
module lcd_frame_scheduler
  import lcd_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ           = 2,
  parameter int unsigned ADDR_W            = LCD_ADDR_W,
  parameter int unsigned DATA_W            = LCD_DATA_W,
  parameter int unsigned MIN_PERIOD_CYCLES = 25000,
  parameter int unsigned BUSY_TIMEOUT      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      lcd_busy,
  output logic                      lcd_trg,
  input  logic [ADDR_W-1:0]         lcd_addr,
  output logic [DATA_W-1:0]         lcd_data,
  output logic                      dirty,
  output logic [15:0]               frame_count,
  output logic                      timeout_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PER_W = (MIN_PERIOD_CYCLES > 1) ? $clog2(MIN_PERIOD_CYCLES) : 1;
  localparam int unsigned TMO_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [PER_W-1:0]  PERIOD_RELOAD = PER_W'(MIN_PERIOD_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST      = TMO_W'(BUSY_TIMEOUT - 1);
  localparam logic [DATA_W-1:0] BLANK         = DATA_W'(BLANK_CHAR);

  state_t               state;
  logic [DATA_W-1:0]    mem [DEPTH];
  logic [PER_W-1:0]     period_cnt;
  logic [TMO_W-1:0]     wait_cnt;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     rr_next;
  logic [NUM_REQ-1:0]   grant;
  logic                 ready_en;
  logic                 launch;
  logic                 arb_en;
  logic                 period_reload;
  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic [DATA_W-1:0]    wr_data;

`ifdef LCD_SCHED_PERIODIC_EN
  assign launch = (state == ST_IDLE) && (dirty || (period_cnt == '0)) &&
                  (period_cnt == '0) && !lcd_busy;
`else
  assign launch = (state == ST_IDLE) && dirty && (period_cnt == '0) && !lcd_busy;
`endif

  // Grants only in IDLE so the driver never reads a half-updated buffer.
  assign arb_en = ready_en && (state == ST_IDLE) && !launch;

  lcd_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .valid    (req_valid),
    .enable   (arb_en),
    .ptr      (rr_ptr),
    .grant    (grant),
    .next_ptr (rr_next)
  );

  assign req_ready = grant;
  assign lcd_data  = mem[lcd_addr];

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (grant[k] && req_valid[k]) begin
        wr_en   = 1'b1;
        wr_addr = req_addr[k*ADDR_W +: ADDR_W];
        wr_data = req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Text buffer: blank on reset, one write per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem <= '{default: BLANK};
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign period_reload = ((state == ST_PRINT) && !lcd_busy) ||
                         ((state == ST_WAIT_BUSY) && !lcd_busy && (wait_cnt == TMO_LAST));

  // Minimum spacing between frame completion (or timeout) and the next launch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_cnt <= '0;
    end else if (period_reload) begin
      period_cnt <= PERIOD_RELOAD;
    end else if (period_cnt != '0) begin
      period_cnt <= period_cnt - 1'b1;
    end
  end

  // Frame sequencing FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      dirty       <= 1'b1;
      lcd_trg     <= 1'b0;
      frame_count <= '0;
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
      rr_ptr      <= '0;
      ready_en    <= 1'b0;
    end else begin
      lcd_trg  <= 1'b0;
      ready_en <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (launch) begin
            state   <= ST_TRIG;
            lcd_trg <= 1'b1;
          end else if (wr_en) begin
            dirty  <= 1'b1;
            rr_ptr <= rr_next;
          end
        end
        ST_TRIG: begin
          dirty    <= 1'b0;
          wait_cnt <= '0;
          state    <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (lcd_busy) begin
            state <= ST_PRINT;
          end else if (wait_cnt == TMO_LAST) begin
            state       <= ST_IDLE;
            dirty       <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_PRINT: begin
          if (!lcd_busy) begin
            state       <= ST_IDLE;
            frame_count <= frame_count + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// Directed self-checking bench for lcd_frame_scheduler with a shortened refresh period.
module tb_lcd_frame_scheduler;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned P       = 64;
  localparam int unsigned TMO     = 4;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      lcd_busy;
  logic                      lcd_trg;
  logic [ADDR_W-1:0]         lcd_addr;
  logic [DATA_W-1:0]         lcd_data;
  logic                      dirty;
  logic [15:0]               frame_count;
  logic                      timeout_err;

  int vectors;
  int errors;

  lcd_frame_scheduler #(
    .NUM_REQ           (NUM_REQ),
    .ADDR_W            (ADDR_W),
    .DATA_W            (DATA_W),
    .MIN_PERIOD_CYCLES (P),
    .BUSY_TIMEOUT      (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .lcd_busy    (lcd_busy),
    .lcd_trg     (lcd_trg),
    .lcd_addr    (lcd_addr),
    .lcd_data    (lcd_data),
    .dirty       (dirty),
    .frame_count (frame_count),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [1:0] v, input logic [5:0] a0, input logic [7:0] d0,
                           input logic [5:0] a1, input logic [7:0] d1);
    req_valid = v;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
    #1;
  endtask

  task automatic read_char(input logic [5:0] a, output logic [7:0] d);
    lcd_addr = a;
    #1;
    d = lcd_data;
  endtask

  task automatic wait_trg(input int start, input int bound, output int n);
    n = start;
    while (lcd_trg !== 1'b1 && n < bound) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst      = 1'b0;
    lcd_busy = 1'b1;
    lcd_addr = '0;
    drive_req(2'b11, 6'd0, 8'h41, 6'd33, 8'h42);
    repeat (3) step();
    vectors++; if (lcd_trg !== 1'b0) begin errors++; $display("FAIL reset_trg got %b want 0", lcd_trg); end
    vectors++; if (dirty !== 1'b1) begin errors++; $display("FAIL reset_dirty got %b want 1", dirty); end
    vectors++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_fc got %0d want 0", frame_count); end
    vectors++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_tmo got %b want 0", timeout_err); end
    vectors++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", req_ready); end
    read_char(6'd63, d);
    vectors++; if (d !== 8'h20) begin errors++; $display("FAIL reset_buf63 got %h want 20", d); end
    drive_req(2'b00, 6'd0, 8'h00, 6'd0, 8'h00);
    rst = 1'b1;
    step();
  endtask

  task automatic test_arbiter();
    logic [7:0] d;
    drive_req(2'b11, 6'd0, 8'h41, 6'd33, 8'h42);
    vectors++; if (req_ready !== 2'b01) begin errors++; $display("FAIL arb_both_rr0 got %b want 01", req_ready); end
    step();
    drive_req(2'b10, 6'd0, 8'h41, 6'd33, 8'h42);
    vectors++; if (req_ready !== 2'b10) begin errors++; $display("FAIL arb_req1_next got %b want 10", req_ready); end
    step();
    drive_req(2'b01, 6'd10, 8'h31, 6'd0, 8'h00);
    step();
    drive_req(2'b11, 6'd40, 8'h58, 6'd40, 8'h59);
    vectors++; if (req_ready !== 2'b10) begin errors++; $display("FAIL arb_rr1 got %b want 10", req_ready); end
    step();
    vectors++; if (req_ready !== 2'b01) begin errors++; $display("FAIL arb_rr_wrap got %b want 01", req_ready); end
    step();
    drive_req(2'b00, 6'd0, 8'h00, 6'd0, 8'h00);
    read_char(6'd0, d);
    vectors++; if (d !== 8'h41) begin errors++; $display("FAIL buf0 got %h want 41", d); end
    read_char(6'd33, d);
    vectors++; if (d !== 8'h42) begin errors++; $display("FAIL buf33 got %h want 42", d); end
    read_char(6'd10, d);
    vectors++; if (d !== 8'h31) begin errors++; $display("FAIL buf10 got %h want 31", d); end
    read_char(6'd40, d);
    vectors++; if (d !== 8'h58) begin errors++; $display("FAIL buf40_lastwins got %h want 58", d); end
    read_char(6'd1, d);
    vectors++; if (d !== 8'h20) begin errors++; $display("FAIL buf1 got %h want 20", d); end
  endtask

  task automatic test_launch();
    int saw;
    saw = 0;
    repeat (190) begin
      step();
      if (lcd_trg !== 1'b0) saw++;
    end
    vectors++; if (saw != 0) begin errors++; $display("FAIL busy_blocks_launch got %0d trg want 0", saw); end
    lcd_busy = 1'b0;
    step();
    vectors++; if (lcd_trg !== 1'b1) begin errors++; $display("FAIL launch_trg got %b want 1", lcd_trg); end
    step();
    vectors++; if (lcd_trg !== 1'b0) begin errors++; $display("FAIL trg_one_cycle got %b want 0", lcd_trg); end
    vectors++; if (dirty !== 1'b0) begin errors++; $display("FAIL launch_dirty got %b want 0", dirty); end
  endtask

  task automatic test_frame();
    int n;
    lcd_busy = 1'b1;
    step();
    repeat (499) step();
    lcd_busy = 1'b0;
    step();
    vectors++; if (frame_count !== 16'd1) begin errors++; $display("FAIL frame1_fc got %0d want 1", frame_count); end
    vectors++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL frame1_tmo got %b want 0", timeout_err); end
    drive_req(2'b01, 6'd5, 8'h5A, 6'd0, 8'h00);
    vectors++; if (req_ready !== 2'b01) begin errors++; $display("FAIL idle_grant got %b want 01", req_ready); end
    step();
    drive_req(2'b00, 6'd0, 8'h00, 6'd0, 8'h00);
    wait_trg(1, int'(P) + 20, n);
    vectors++; if (n != int'(P)) begin errors++; $display("FAIL min_period got %0d cycles want %0d", n, P); end
    vectors++; if (dirty !== 1'b1) begin errors++; $display("FAIL period_dirty got %b want 1", dirty); end
  endtask

  task automatic test_print_freeze();
    int bad;
    logic [7:0] d;
    step();
    lcd_busy = 1'b1;
    step();
    drive_req(2'b01, 6'd7, 8'h37, 6'd0, 8'h00);
    bad = 0;
    repeat (20) begin
      if (req_ready !== 2'b00) bad++;
      step();
    end
    vectors++; if (bad != 0) begin errors++; $display("FAIL print_ready got %0d grants want 0", bad); end
    read_char(6'd7, d);
    vectors++; if (d !== 8'h20) begin errors++; $display("FAIL print_frozen got %h want 20", d); end
    lcd_busy = 1'b0;
    step();
    vectors++; if (req_ready !== 2'b01) begin errors++; $display("FAIL first_idle_grant got %b want 01", req_ready); end
    step();
    drive_req(2'b00, 6'd0, 8'h00, 6'd0, 8'h00);
    read_char(6'd7, d);
    vectors++; if (d !== 8'h37) begin errors++; $display("FAIL post_print_write got %h want 37", d); end
    vectors++; if (frame_count !== 16'd2) begin errors++; $display("FAIL frame2_fc got %0d want 2", frame_count); end
  endtask

  task automatic test_timeout();
    int n;
    wait_trg(1, int'(P) + 20, n);
    vectors++; if (n != int'(P)) begin errors++; $display("FAIL relaunch2 got %0d cycles want %0d", n, P); end
    step();
    vectors++; if (dirty !== 1'b0) begin errors++; $display("FAIL tmo_dirty_clr got %b want 0", dirty); end
    repeat (TMO - 1) step();
    vectors++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_early got %b want 0", timeout_err); end
    step();
    vectors++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_set got %b want 1", timeout_err); end
    vectors++; if (dirty !== 1'b1) begin errors++; $display("FAIL tmo_dirty got %b want 1", dirty); end
    wait_trg(0, int'(P) + 20, n);
    vectors++; if (n != int'(P)) begin errors++; $display("FAIL tmo_relaunch got %0d cycles want %0d", n, P); end
    vectors++; if (frame_count !== 16'd2) begin errors++; $display("FAIL tmo_fc got %0d want 2", frame_count); end
    step();
    lcd_busy = 1'b1;
    step();
    repeat (10) step();
  endtask

  task automatic test_reset_mid_print();
    int n;
    logic [7:0] d;
    rst      = 1'b0;
    lcd_busy = 1'b0;
    drive_req(2'b11, 6'd0, 8'h41, 6'd33, 8'h42);
    vectors++; if (dirty !== 1'b1 || timeout_err !== 1'b0 || lcd_trg !== 1'b0)
      begin errors++; $display("FAIL midreset_flags got d%b t%b g%b want d1 t0 g0", dirty, timeout_err, lcd_trg); end
    vectors++; if (frame_count !== 16'd0) begin errors++; $display("FAIL midreset_fc got %0d want 0", frame_count); end
    vectors++; if (req_ready !== 2'b00) begin errors++; $display("FAIL midreset_ready got %b want 00", req_ready); end
    read_char(6'd40, d);
    vectors++; if (d !== 8'h20) begin errors++; $display("FAIL midreset_buf40 got %h want 20", d); end
    read_char(6'd7, d);
    vectors++; if (d !== 8'h20) begin errors++; $display("FAIL midreset_buf7 got %h want 20", d); end
    drive_req(2'b00, 6'd0, 8'h00, 6'd0, 8'h00);
    step();
    rst = 1'b1;
    step();
    vectors++; if (lcd_trg !== 1'b1) begin errors++; $display("FAIL postreset_trg got %b want 1", lcd_trg); end
    step();
    lcd_busy = 1'b1;
    step();
    repeat (5) step();
    lcd_busy = 1'b0;
    step();
    vectors++; if (frame_count !== 16'd1) begin errors++; $display("FAIL postreset_fc got %0d want 1", frame_count); end
`ifdef LCD_SCHED_PERIODIC_EN
    wait_trg(0, int'(P) + 20, n);
    vectors++; if (n != int'(P)) begin errors++; $display("FAIL periodic_trg got %0d cycles want %0d", n, P); end
`else
    wait_trg(0, 3 * int'(P), n);
    vectors++; if (lcd_trg !== 1'b0) begin errors++; $display("FAIL idle_no_trg got trg after %0d cycles want none", n); end
`endif
  endtask

  initial begin
    vectors   = 0;
    errors    = 0;
    rst       = 1'b0;
    lcd_busy  = 1'b1;
    lcd_addr  = '0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    test_reset();
    test_arbiter();
    test_launch();
    test_frame();
    test_print_freeze();
    test_timeout();
    test_reset_mid_print();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
